dmem_arbiter: RTL

Two-port arbiter and sequencer for the single-port 8-bit data memory (combinational read, clocked write). It shares the memory between port 0 (core load/store unit) and port 1 (program loader / DMA). It uses round-robin fairness with an optional bounded lock for atomic multi-access sequences. It sits between both requesters and the memory and is the only driver of the memory's address, enable and write-data pins.

---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/dmem_arbiter_if.sv | 33 +++
 rtl/dmem_port_mux.sv | 39 +++
 rtl/dmem_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Port index: 0 = core load/store unit, 1 = program loader / DMA.
  typedef logic port_t;

  localparam int unsigned AwDefault      = 8;
  localparam int unsigned LockMaxDefault = 4;

  function automatic port_t other_port(input port_t p);
    return ~p;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-pin bundle. The master side is both requesters plus the memory;
// the slave side is the arbiter.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 8
) ();

  logic          Req0, Req1;
  logic          We0, We1;
  logic          Lock0, Lock1;
  logic [AW-1:0] Addr0, Addr1;
  logic [7:0]    WData0, WData1;
  logic          Gnt0, Gnt1;
  logic [7:0]    RData0, RData1;
  logic          RValid0, RValid1;
  logic [AW-1:0] MemAddress;
  logic          MemRead;
  logic          MemWrite;
  logic [7:0]    MemDataIn;
  logic [7:0]    MemDataOut;

  modport master (
    output Req0, Req1, We0, We1, Lock0, Lock1, Addr0, Addr1, WData0, WData1, MemDataOut,
    input  Gnt0, Gnt1, RData0, RData1, RValid0, RValid1,
    input  MemAddress, MemRead, MemWrite, MemDataIn
  );

  modport slave (
    input  Req0, Req1, We0, We1, Lock0, Lock1, Addr0, Addr1, WData0, WData1, MemDataOut,
    output Gnt0, Gnt1, RData0, RData1, RValid0, RValid1,
    output MemAddress, MemRead, MemWrite, MemDataIn
  );

endinterface

// File: rtl/dmem_port_mux.sv
// Combinational selection of the memory pins from the owning port.
module dmem_port_mux
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW = AwDefault
) (
  input  logic          own_valid_i,
  input  port_t         owner_i,
  input  logic          block_i,
  input  logic [1:0]    req_i,
  input  logic [1:0]    we_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [7:0]    wdata0_i,
  input  logic [7:0]    wdata1_i,
  output logic [1:0]    gnt_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_read_o,
  output logic          mem_write_o,
  output logic [7:0]    mem_wdata_o
);

  // An access happens only when the owner requests and reset is low; otherwise pins idle at 0.
  always_comb begin
    gnt_o       = '0;
    mem_addr_o  = '0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    mem_wdata_o = '0;
    if (own_valid_i && !block_i && req_i[owner_i]) begin
      gnt_o[owner_i] = 1'b1;
      mem_addr_o     = owner_i ? addr1_i : addr0_i;
      mem_wdata_o    = owner_i ? wdata1_i : wdata0_i;
      mem_read_o     = !we_i[owner_i];
      mem_write_o    = we_i[owner_i];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for a single-port data memory with a bounded ownership lock.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW       = AwDefault,
  parameter int unsigned LOCK_MAX = LockMaxDefault
) (
  input logic           CLK,
  input logic           Reset,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned      HoldW   = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [HoldW-1:0] HoldMax = HoldW'(LOCK_MAX - 1);

  arb_state_t       state_q, state_d;
  port_t            prio_q, prio_d;
  logic [HoldW-1:0] holdcnt_q, holdcnt_d;

  logic       own_valid;
  port_t      owner;
  logic [1:0] req, we, lock, gnt;
  logic       req_own, req_oth, lock_own;

  logic [1:0] rvalid_q, rvalid_d;
  logic [7:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic [AW-1:0] mem_addr;
  logic          mem_read, mem_write;
  logic [7:0]    mem_wdata;

  assign req      = {bus.Req1, bus.Req0};
  assign we       = {bus.We1, bus.We0};
  assign lock     = {bus.Lock1, bus.Lock0};
  assign req_own  = req[owner];
  assign req_oth  = req[other_port(owner)];
  assign lock_own = lock[owner];

  // FSM state register: state, tie-break priority and lock hold counter.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      holdcnt_q <= '0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      holdcnt_q <= holdcnt_d;
    end
  end

  // FSM next state: ordered ownership rules, first match wins.
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    holdcnt_d = holdcnt_q;
    unique case (state_q)
      IDLE: begin
        if (req[0] && req[1]) begin
          state_d = prio_q ? OWN1 : OWN0;
        end else if (req[0]) begin
          state_d = OWN0;
        end else if (req[1]) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (req_own && lock_own && (holdcnt_q < HoldMax)) begin
          holdcnt_d = holdcnt_q + 1'b1;
        end else if (req_oth) begin
          state_d   = owner ? OWN0 : OWN1;
          holdcnt_d = '0;
          prio_d    = owner;
        end else if (req_own) begin
          if (holdcnt_q < HoldMax) holdcnt_d = holdcnt_q + 1'b1;
        end else begin
          state_d   = IDLE;
          holdcnt_d = '0;
          prio_d    = other_port(owner);
        end
      end
      default: begin
        state_d   = IDLE;
        holdcnt_d = '0;
      end
    endcase
  end

  // FSM outputs: which port, if any, owns the memory.
  always_comb begin
    own_valid = 1'b0;
    owner     = 1'b0;
    unique case (state_q)
      OWN0: own_valid = 1'b1;
      OWN1: begin
        own_valid = 1'b1;
        owner     = 1'b1;
      end
      default: ;
    endcase
  end

  dmem_port_mux #(
    .AW (AW)
  ) u_port_mux (
    .own_valid_i (own_valid),
    .owner_i     (owner),
    .block_i     (Reset),
    .req_i       (req),
    .we_i        (we),
    .addr0_i     (bus.Addr0),
    .addr1_i     (bus.Addr1),
    .wdata0_i    (bus.WData0),
    .wdata1_i    (bus.WData1),
    .gnt_o       (gnt),
    .mem_addr_o  (mem_addr),
    .mem_read_o  (mem_read),
    .mem_write_o (mem_write),
    .mem_wdata_o (mem_wdata)
  );

  // Read return: capture memory data on a read grant; RData holds between reads.
  always_comb begin
    rvalid_d = gnt & ~we;
    rdata0_d = rvalid_d[0] ? bus.MemDataOut : rdata0_q;
    rdata1_d = rvalid_d[1] ? bus.MemDataOut : rdata1_q;
  end

  // Read-return registers.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      rvalid_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign bus.Gnt0       = gnt[0];
  assign bus.Gnt1       = gnt[1];
  assign bus.MemAddress = mem_addr;
  assign bus.MemRead    = mem_read;
  assign bus.MemWrite   = mem_write;
  assign bus.MemDataIn  = mem_wdata;
  assign bus.RValid0    = rvalid_q[0];
  assign bus.RValid1    = rvalid_q[1];
  assign bus.RData0     = rdata0_q;
  assign bus.RData1     = rdata1_q;

endmodule
